// File: rtl/decoder_proj_pkg.sv
// Shared definitions for the decoder_proj slot: io_in field layout, mode
// encoding, seven-segment glyphs and the hit-counter ceiling.
package decoder_proj_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'd0,
        MODE_SEG7   = 2'd1,
        MODE_THERM  = 2'd2,
        MODE_BCD    = 2'd3
    } mode_e;

    localparam int V_LSB  = 0;
    localparam int V_W    = 4;
    localparam int EN_BIT = 4;
    localparam int M_LSB  = 5;
    localparam int M_W    = 2;

    // Active-high gfedcba, digit F in the top slot down to digit 0 at the bottom
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] HITS_MAX = 8'hFF;

endpackage

// File: rtl/decoder_proj_seg7_lut.sv
// Hex digit to seven-segment glyph, purely combinational.
module seg7_lut
    import decoder_proj_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[digit];

endmodule

// File: rtl/decoder_proj_formal_wrap.sv
// Registered multi-mode 4-bit decoder: one-hot, seven-segment, thermometer or
// BCD view of io_in, presented one clock after sampling, plus a hit counter.
module decoder_proj_formal_wrap
    import decoder_proj_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  io_in,
    output logic [15:0] io_out,
    output logic        valid,
    output logic [7:0]  hits
);

    logic [1:0]  rst_sync;
    logic        sample_en;
    logic [3:0]  value;
    logic        en;
    mode_e       mode;
    logic [6:0]  seg;
    logic [15:0] decoded;

    // Reset asserts asynchronously but releases through two flops, so the
    // datapath never starts on an edge that races the rst_n deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign sample_en = rst_sync[1];
    assign value     = io_in[V_LSB +: V_W];
    assign en        = io_in[EN_BIT];
    assign mode      = mode_e'(io_in[M_LSB +: M_W]);

    seg7_lut u_seg7 (
        .digit (value),
        .seg   (seg)
    );

    always_comb begin
        decoded = '0;
        unique case (mode)
            MODE_ONEHOT: decoded[value] = 1'b1;
            MODE_SEG7:   decoded[6:0]   = seg;
            MODE_THERM: begin
                for (int i = 0; i < 16; i++)
                    decoded[i] = (5'(i) <= {1'b0, value});
            end
            MODE_BCD: begin
                if (value >= 4'd10) begin
                    decoded[7:4] = 4'd1;
                    decoded[3:0] = value - 4'd10;
                end else begin
                    decoded[3:0] = value;
                end
            end
            default: decoded = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_out <= '0;
            valid  <= 1'b0;
            hits   <= '0;
        end else if (sample_en) begin
            valid  <= en;
            io_out <= en ? decoded : '0;
            if (en && hits != HITS_MAX)
                hits <= hits + 8'd1;
        end
    end

`ifdef FORMAL
    cover property (@(posedge clk) valid && $past(io_in[M_LSB +: M_W]) == MODE_ONEHOT);
    cover property (@(posedge clk) valid && $past(io_in[M_LSB +: M_W]) == MODE_SEG7);
    cover property (@(posedge clk) valid && $past(io_in[M_LSB +: M_W]) == MODE_THERM);
    cover property (@(posedge clk) valid && $past(io_in[M_LSB +: M_W]) == MODE_BCD);
    cover property (@(posedge clk) hits == HITS_MAX);

    assert property (@(posedge clk) disable iff (!rst_n)
        ($past(sample_en) && $past(en) && $past(io_in[M_LSB +: M_W]) == MODE_ONEHOT)
            |-> $onehot(io_out));
    assert property (@(posedge clk) !valid |-> io_out == '0);
`endif

endmodule

// File: tb/tb_decoder_proj_formal_wrap.sv
// Directed-vector bench: stimulus pushes expected responses into a queue,
// a monitor pops and compares one entry per clock after each sampling edge.
module tb_decoder_proj_formal_wrap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  io_in;
    logic [15:0] io_out;
    logic        valid;
    logic [7:0]  hits;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic        vld;
        logic [7:0]  hits;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  m_hits  = 8'h00;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    decoder_proj_formal_wrap dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_in  (io_in),
        .io_out (io_out),
        .valid  (valid),
        .hits   (hits)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] eo, input logic ev,
                         input logic [7:0] eh);
        vectors++;
        if (io_out !== eo || valid !== ev || hits !== eh) begin
            errors++;
            $display("FAIL %s: got io_out=%h valid=%b hits=%h, want io_out=%h valid=%b hits=%h",
                     name, io_out, valid, hits, eo, ev, eh);
        end
    endtask

    // Drive one sample; eo is the hand-derived decode used when EN=1.
    task automatic apply(input string name, input logic [6:0] v, input logic [15:0] eo);
        exp_t e;
        @(negedge clk);
        io_in = v;
        if (v[4] && m_hits != 8'hFF) m_hits = m_hits + 8'd1;
        e.name = name;
        e.out  = v[4] ? eo : 16'h0000;
        e.vld  = v[4];
        e.hits = m_hits;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, e.out, e.vld, e.hits);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] v;
        rst_n = 1'b0;
        io_in = 7'h7F;
        repeat (3) @(posedge clk);
        #1 check("reset", 16'h0000, 1'b0, 8'h00);

        @(negedge clk);
        io_in = 7'h00;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        apply("therm_v6", 7'b1010110, 16'h007F);
        apply("therm_vF", 7'b1011111, 16'hFFFF);
        apply("therm_v0", 7'b1010000, 16'h0001);

        for (int i = 0; i < 16; i++) begin
            v = {2'b00, 1'b1, 4'(i)};
            apply("onehot", v, 16'h0001 << i);
        end
        for (int i = 0; i < 16; i++) begin
            v = {2'b01, 1'b1, 4'(i)};
            apply("seg7", v, {9'h000, seg_tab[i]});
        end

        apply("bcd_12", 7'b1111100, 16'h0012);
        apply("bcd_9",  7'b1111001, 16'h0009);
        apply("bcd_15", 7'b1111111, 16'h0015);
        apply("bcd_0",  7'b1110000, 16'h0000);

        apply("disable", 7'b1001111, 16'h0000);
        apply("reenable", 7'b0110101, 16'h006D);

        for (int i = 0; i < 300; i++)
            apply("saturate", 7'b0010000, 16'h0001);
        apply("sat_hold_dis", 7'b1001111, 16'h0000);
        drain();

        // Reset mid-high-phase: outputs must clear before the next edge.
        @(posedge clk);
        io_in = 7'b1011111;
        #3 rst_n = 1'b0;
        #1 check("async_reset", 16'h0000, 1'b0, 8'h00);
        @(posedge clk);
        #1 check("reset_hold", 16'h0000, 1'b0, 8'h00);

        @(negedge clk);
        io_in  = 7'h00;
        rst_n  = 1'b1;
        m_hits = 8'h00;
        repeat (3) @(posedge clk);
        apply("post_reset_therm", 7'b1010110, 16'h007F);
        apply("post_reset_onehot", 7'b0010011, 16'h0008);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
